// File: rtl/lcd1602_num_display.sv
// HD44780 16x2 numeric field: initialises the panel, converts an unsigned
// value to decimal and rewrites the field whenever the input value changes.
module lcd1602_num_display #(
   parameter int IN_WIDTH    = 7,
   parameter int NUM_DIGITS  = 3,
   parameter int WAIT_CYCLES = 100000,
   parameter int ROW         = 0,
   parameter int COL         = 0,
   parameter int BLANK_ZEROS = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ready_i,
   input  logic [IN_WIDTH-1:0] in,
   output logic                rs,
   output logic                rw,
   output logic                enable,
   output logic [7:0]          data,
   output logic                busy_o
);

   localparam int CW   = $clog2(WAIT_CYCLES);
   localparam int BW   = $clog2(IN_WIDTH + 1);
   localparam int XW   = $clog2(NUM_DIGITS + 5);
   localparam int BCDW = 4 * NUM_DIGITS;

   localparam logic [7:0] ADDR_CMD = 8'h80 | 8'(ROW * 64 + COL);

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      SAMPLE,
      CONVERT,
      WRITE,
      HOLD
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [XW-1:0]       idx_q, idx_d;
   logic [BW-1:0]       bit_q, bit_d;
   logic [IN_WIDTH-1:0] val_q, val_d;
   logic [IN_WIDTH-1:0] sh_q, sh_d;
   logic [BCDW-1:0]     bcd_q, bcd_d;
   logic                rs_q, rs_d;
   logic                en_q, en_d;
   logic [7:0]          data_q, data_d;
   logic                busy_q, busy_d;

   logic                       slot_end;
   logic                       pulse;
   logic [7:0]                 init_byte;
   logic [7:0]                 char_byte;
   logic [3:0]                 dig;
   logic                       blank;
   logic                       zrun;
   logic [NUM_DIGITS-1:0]      lead;
   logic [BCDW-1:0]            adj;
   logic [BCDW+IN_WIDTH-1:0]   cat;

   assign slot_end = (cnt_q == CW'(WAIT_CYCLES - 1));
   assign pulse    = (cnt_q != '0) && (cnt_q <= CW'(WAIT_CYCLES / 2));

   always_comb begin
      unique case (idx_q[1:0])
         2'd0:    init_byte = 8'h38;
         2'd1:    init_byte = 8'h0C;
         2'd2:    init_byte = 8'h01;
         default: init_byte = 8'h06;
      endcase
   end

   // lead[p] marks digits that are zero along with every digit above them
   always_comb begin
      zrun  = 1'b1;
      lead  = '0;
      dig   = '0;
      blank = 1'b0;
      adj   = '0;
      for (int p = NUM_DIGITS - 1; p >= 0; p--) begin
         zrun    = zrun && (bcd_q[4*p +: 4] == 4'd0);
         lead[p] = zrun;
      end
      for (int p = 0; p < NUM_DIGITS; p++) begin
         if (idx_q == XW'(NUM_DIGITS - p)) begin
            dig   = bcd_q[4*p +: 4];
            blank = (BLANK_ZEROS != 0) && (p != 0) && lead[p];
         end
         if (bcd_q[4*p +: 4] >= 4'd5)
            adj[4*p +: 4] = bcd_q[4*p +: 4] + 4'd3;
         else
            adj[4*p +: 4] = bcd_q[4*p +: 4];
      end
      char_byte = blank ? 8'h20 : {4'h3, dig};
      cat       = {adj, sh_q} << 1;
   end

   // Outputs are derived from the current state, so they trail it by a cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      bit_d   = bit_q;
      val_d   = val_q;
      sh_d    = sh_q;
      bcd_d   = bcd_q;
      rs_d    = rs_q;
      en_d    = 1'b0;
      data_d  = data_q;
      busy_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            rs_d   = 1'b0;
            data_d = 8'h00;
            if (ready_i) begin
               state_d = INIT;
               cnt_d   = '0;
               idx_d   = '0;
            end
         end
         INIT: begin
            busy_d = 1'b1;
            rs_d   = 1'b0;
            data_d = init_byte;
            en_d   = pulse;
            cnt_d  = slot_end ? '0 : cnt_q + 1'b1;
            if (slot_end) begin
               if (idx_q == XW'(3)) state_d = SAMPLE;
               else                 idx_d   = idx_q + 1'b1;
            end
         end
         SAMPLE: begin
            busy_d  = 1'b1;
            val_d   = in;
            sh_d    = in;
            bcd_d   = '0;
            bit_d   = '0;
            state_d = CONVERT;
         end
         CONVERT: begin
            busy_d = 1'b1;
            bcd_d  = cat[BCDW+IN_WIDTH-1:IN_WIDTH];
            sh_d   = cat[IN_WIDTH-1:0];
            bit_d  = bit_q + 1'b1;
            if (bit_q == BW'(IN_WIDTH - 1)) begin
               state_d = WRITE;
               cnt_d   = '0;
               idx_d   = '0;
            end
         end
         WRITE: begin
            busy_d = 1'b1;
            rs_d   = (idx_q != '0);
            data_d = (idx_q == '0) ? ADDR_CMD : char_byte;
            en_d   = pulse;
            cnt_d  = slot_end ? '0 : cnt_q + 1'b1;
            if (slot_end) begin
               if (idx_q == XW'(NUM_DIGITS)) state_d = HOLD;
               else                          idx_d   = idx_q + 1'b1;
            end
         end
         HOLD: begin
            if (in != val_q) state_d = SAMPLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         bit_q   <= '0;
         val_q   <= '0;
         sh_q    <= '0;
         bcd_q   <= '0;
         rs_q    <= 1'b0;
         en_q    <= 1'b0;
         data_q  <= 8'h00;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         bit_q   <= bit_d;
         val_q   <= val_d;
         sh_q    <= sh_d;
         bcd_q   <= bcd_d;
         rs_q    <= rs_d;
         en_q    <= en_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
      end
   end

   assign rs     = rs_q;
   assign rw     = 1'b0;
   assign enable = en_q;
   assign data   = data_q;
   assign busy_o = busy_q;

endmodule

// File: doc/lcd1602_num_display.md
LCD1602_NUM_DISPLAY -- requirements
Module: lcd1602_num_display

Interface
REQ-001 Parameter IN_WIDTH, 7, bit width of unsigned binary value to display.
REQ-002 Parameter NUM_DIGITS, 3, decimal field width; SHALL satisfy 10^NUM_DIGITS > 2^IN_WIDTH-1, otherwise high digits are truncated (modulo 10^NUM_DIGITS).
REQ-003 Parameter WAIT_CYCLES, 100000, clocks per LCD byte slot (2 ms at 50 MHz; covers clear-display time); even, >= 4.
REQ-004 Parameter ROW, 0, display line: 0 -> DDRAM base 0x00, 1 -> 0x40.
REQ-005 Parameter COL, 0, start column 0..16-NUM_DIGITS.
REQ-006 Parameter BLANK_ZEROS, 1, 1 -> leading zeros shown as space 0x20; least-significant digit always shown.
REQ-007 clk  input  1  system clock, all logic on rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 ready_i  input  1  high when LCD supply is stable and init may start.
REQ-010 in  input  IN_WIDTH  unsigned value to display.
REQ-011 rs  output  1  LCD register select (0 command, 1 data).
REQ-012 rw  output  1  LCD read/write, constant 0.
REQ-013 enable  output  1  LCD E strobe.
REQ-014 data  output  8  LCD DB7..DB0.
REQ-015 busy_o  output  1  high while init, conversion or a write sequence is in progress.

Function
REQ-016 FSM states SHALL be: IDLE, INIT, SAMPLE, CONVERT, WRITE, HOLD.
REQ-017 IDLE: outputs low; move to INIT on first edge with ready_i=1; ready_i ignored in all other states.
REQ-018 INIT: four command slots, rs=0, bytes in order 0x38, 0x0C, 0x01, 0x06; then SAMPLE.
REQ-019 Slot timing: slot counter 0..WAIT_CYCLES-1; rs/data valid from count 0 to slot end; enable=1 for counts 1..WAIT_CYCLES/2, else 0; next slot starts immediately after count WAIT_CYCLES-1.
REQ-020 SAMPLE: one cycle, latch in into value register; go to CONVERT.
REQ-021 CONVERT: iterative shift-add-3 binary-to-BCD, exactly IN_WIDTH cycles, enable held 0; then WRITE.
REQ-022 WRITE: one command slot rs=0, data=0x80|(ROW*0x40+COL), then NUM_DIGITS data slots rs=1, most-significant digit first, char 0x30+digit or 0x20 per REQ-006; then HOLD.
REQ-023 HOLD: busy_o=0, enable=0; each cycle compare in with latched value; on mismatch go SAMPLE next edge; no LCD traffic while equal.
REQ-024 Changes of in during CONVERT or WRITE SHALL NOT alter the sequence in flight; a differing in is picked up on the first HOLD cycle.
REQ-025 Value 0 SHALL display as NUM_DIGITS-1 spaces then '0' (BLANK_ZEROS=1) or all '0' (BLANK_ZEROS=0).
REQ-026 Maximum value 2^IN_WIDTH-1 SHALL display exactly, no wrap, when REQ-002 holds.
REQ-027 busy_o=1 in INIT, SAMPLE, CONVERT, WRITE; 0 in IDLE, HOLD.
REQ-028 Update latency: first enable rise of WRITE SHALL occur IN_WIDTH+3 cycles after the edge where HOLD sees the mismatch.

Reset
REQ-029 On reset=1 at a rising edge: state IDLE, rs=0, rw=0, enable=0, data=0x00, busy_o=0, slot counter, value and BCD registers cleared.
REQ-030 Reset mid-slot SHALL drop enable on that same edge and restart from IDLE, requiring ready_i again; reset has priority over all other events.

Verification (IN_WIDTH=7, NUM_DIGITS=3, WAIT_CYCLES=8, ROW=0, COL=0, BLANK_ZEROS=1)
REQ-031 reset high 5 cycles, ready_i=0 -> all outputs 0, busy_o=0, no enable pulse for 100 cycles.
REQ-032 ready_i=1, in=0 -> bytes 0x38,0x0C,0x01,0x06 (rs=0), 0x80 (rs=0), 0x20,0x20,0x30 (rs=1), each enable pulse 4 cycles high per 8-cycle slot; busy_o falls after last slot.
REQ-033 in=123 in HOLD -> 0x80 then '1','2','3' (0x31,0x32,0x33); first enable rise exactly 10 cycles after mismatch edge.
REQ-034 in=127 then in=7 -> "127" then "  7" (0x20,0x20,0x37); no traffic while in stable.
REQ-035 in toggles 5->9 during WRITE of 5 -> sequence for 5 completes unchanged, then a full update to "  9".
REQ-036 reset asserted mid-data slot with enable=1 -> enable=0 next edge, IDLE, re-init on ready_i.
